// File: rtl/mem_access_unit.sv
// Memory access unit: runs one load, store or fetch at a time against a synchronous
// 32-bit memory, aligning and extending load data and flagging misaligned requests.
module mem_access_unit #(
    parameter int READ_LATENCY = 2,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  Clk,
    input  logic                  Reset_signal,
    input  logic                  req,
    input  logic                  wr,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [31:0]           WriteData,
    output logic [31:0]           ReadData,
    output logic                  busy,
    output logic                  done,
    output logic                  addr_err,
    output logic [ADDR_WIDTH-1:0] Mem_addr,
    output logic [31:0]           Mem_wdata,
    output logic                  Mem_wr,
    output logic [3:0]            Mem_byte_en,
    input  logic [31:0]           Mem_rdata
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    // cnt is 0 on the first READ cycle, so the sampling edge is the one leaving cnt = L-1
    localparam logic [2:0] CNT_LAST = 3'(READ_LATENCY - 1);

    logic [2:0]            state;
    logic [2:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;
    logic [1:0]            size_q;
    logic                  sign_ext_q;
    logic [31:0]           wdata_q;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b01:   return lane[0];
            2'b10:   return 1'b0;
            default: return lane != 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] align_load(input logic [31:0] rdata, input logic [1:0] lane,
                                               input logic [1:0] sz, input logic sx);
        logic [31:0]        shifted;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] b_ext;
        logic signed [31:0] h_ext;
        shifted = rdata >> {lane, 3'b000};
        b       = shifted[7:0];
        h       = shifted[15:0];
        b_ext   = b;
        h_ext   = h;
        case (sz)
            2'b10:   return sx ? b_ext : {24'h0, shifted[7:0]};
            2'b01:   return sx ? h_ext : {16'h0, shifted[15:0]};
            default: return rdata;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [31:0] wd, input logic [1:0] sz);
        case (sz)
            2'b10:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b10:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    always_ff @(posedge Clk or posedge Reset_signal) begin
        if (Reset_signal) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            size_q     <= 2'b00;
            sign_ext_q <= 1'b0;
            wdata_q    <= '0;
            ReadData   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        addr_q     <= Addr;
                        wr_q       <= wr;
                        size_q     <= size;
                        sign_ext_q <= sign_ext;
                        wdata_q    <= WriteData;
                        cnt        <= '0;
                        if (is_misaligned(size, Addr[1:0]))
                            state <= ST_ERR;
                        else if (wr)
                            state <= ST_WRITE;
                        else
                            state <= ST_READ;
                    end
                end
                ST_READ: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == CNT_LAST) begin
                        ReadData <= align_load(Mem_rdata, addr_q[1:0], size_q, sign_ext_q);
                        state    <= ST_DONE;
                    end
                end
                ST_WRITE: state <= ST_DONE;
                ST_DONE:  state <= ST_IDLE;
                ST_ERR:   state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign addr_err    = (state == ST_ERR);
    assign Mem_wr      = (state == ST_WRITE) && wr_q;
    assign Mem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign Mem_wdata   = lane_wdata(wdata_q, size_q);
    assign Mem_byte_en = Mem_wr ? lane_enables(size_q, addr_q[1:0]) : 4'b0000;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written corner sequences and
// randomized traffic checked against a word-array reference model.
module tb_mem_access_unit;

    localparam int RL = 2;

    logic        Clk;
    logic        Reset_signal;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        busy;
    logic        done;
    logic        addr_err;
    logic [31:0] Mem_addr;
    logic [31:0] Mem_wdata;
    logic        Mem_wr;
    logic [3:0]  Mem_byte_en;
    logic [31:0] Mem_rdata;

    mem_access_unit #(.READ_LATENCY(RL), .ADDR_WIDTH(32)) dut (
        .Clk(Clk), .Reset_signal(Reset_signal), .req(req), .wr(wr), .size(size),
        .sign_ext(sign_ext), .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
        .busy(busy), .done(done), .addr_err(addr_err), .Mem_addr(Mem_addr),
        .Mem_wdata(Mem_wdata), .Mem_wr(Mem_wr), .Mem_byte_en(Mem_byte_en),
        .Mem_rdata(Mem_rdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous memory device: one register stage, data valid RL edges after the address.
    logic [31:0] mem [0:63];
    logic [31:0] rd_p;
    logic [31:0] mem_merged;
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_val;

    always_comb begin
        mem_merged = mem[Mem_addr[7:2]];
        for (int i = 0; i < 4; i++)
            if (Mem_byte_en[i]) mem_merged[8*i +: 8] = Mem_wdata[8*i +: 8];
    end

    always @(posedge Clk) begin
        if (pre_we)      mem[pre_idx] <= pre_val;
        else if (Mem_wr) mem[Mem_addr[7:2]] <= mem_merged;
        rd_p <= mem[Mem_addr[7:2]];
    end
    assign Mem_rdata = rd_p;

    // Reference model state
    logic [31:0] ref_mem [0:63];
    logic [31:0] ref_rd;
    int nerr;
    int nchk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic model_misaligned(input logic [1:0] sz, input logic [1:0] lane);
        if (sz == 2'b10) return 1'b0;
        if (sz == 2'b01) return lane[0];
        return lane != 2'b00;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                               input logic sx, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        if (sz == 2'b10) return (sx && b[7]) ? {24'hFFFFFF, b} : {24'h0, b};
        if (sz == 2'b01) return (sx && h[15]) ? {16'hFFFF, h} : {16'h0, h};
        return word;
    endfunction

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        pre_idx = idx;
        pre_val = val;
        pre_we  = 1'b1;
        ref_mem[idx] = val;
        @(negedge Clk);
        pre_we = 1'b0;
    endtask

    // One complete access, started at a negedge with the DUT idle; ends at a negedge, idle.
    task automatic txn(input logic w, input logic [1:0] sz, input logic sx, input logic [7:0] a,
                       input logic [31:0] wd, output logic err_o, output logic [3:0] be_o,
                       output logic [31:0] wdat_o);
        logic        mis;
        logic [31:0] waddr;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
        logic        found;
        int          k;
        mis   = model_misaligned(sz, a[1:0]);
        waddr = {24'h0, a[7:2], 2'b00};
        req = 1'b1; wr = w; size = sz; sign_ext = sx; Addr = {24'h0, a}; WriteData = wd;
        @(negedge Clk);
        req = 1'b0; wr = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
        Addr = $urandom; WriteData = $urandom;
        err_o  = addr_err;
        be_o   = Mem_byte_en;
        wdat_o = Mem_wdata;
        if (mis) begin
            chk("err_pulse", addr_err, 1'b1);
            chk("err_mem_wr", Mem_wr, 1'b0);
            chk("err_done", done, 1'b0);
            chk("err_busy", busy, 1'b1);
            @(negedge Clk);
            chk("err_clear", addr_err, 1'b0);
            chk("err_idle_busy", busy, 1'b0);
            chk("err_no_done", done, 1'b0);
            chk("err_rd_hold", ReadData, ref_rd);
        end else if (w) begin
            case (sz)
                2'b10:   begin exp_be = 4'b0001 << a[1:0]; exp_wd = {4{wd[7:0]}}; end
                2'b01:   begin exp_be = a[1] ? 4'b1100 : 4'b0011; exp_wd = {2{wd[15:0]}}; end
                default: begin exp_be = 4'b1111; exp_wd = wd; end
            endcase
            chk("wr_mem_wr", Mem_wr, 1'b1);
            chk("wr_byte_en", Mem_byte_en, exp_be);
            chk("wr_wdata", Mem_wdata, exp_wd);
            chk("wr_addr", Mem_addr, waddr);
            chk("wr_early_done", done, 1'b0);
            chk("wr_no_err", addr_err, 1'b0);
            for (int i = 0; i < 4; i++)
                if (exp_be[i]) ref_mem[a[7:2]][8*i +: 8] = exp_wd[8*i +: 8];
            @(negedge Clk);
            chk("wr_done", done, 1'b1);
            chk("wr_single_cycle", Mem_wr, 1'b0);
            chk("wr_be_idle", Mem_byte_en, 4'b0000);
            @(negedge Clk);
            chk("wr_idle_busy", busy, 1'b0);
            chk("wr_rd_hold", ReadData, ref_rd);
        end else begin
            exp_rd = model_load(ref_mem[a[7:2]], sz, sx, a[1:0]);
            found  = 1'b0;
            k      = 0;
            while (!found && k < 20) begin
                chk("rd_mem_wr", Mem_wr, 1'b0);
                chk("rd_addr", Mem_addr, waddr);
                if (done) found = 1'b1;
                else begin
                    @(negedge Clk);
                    k++;
                end
            end
            chk("rd_latency", k, RL);
            chk("rd_data", ReadData, exp_rd);
            ref_rd = exp_rd;
            @(negedge Clk);
            chk("rd_idle_busy", busy, 1'b0);
            chk("rd_idle_done", done, 1'b0);
        end
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sx;
        logic [7:0]  a;
        logic [31:0] wd;
        logic        pre;
        logic [31:0] mword;
        logic        err;
        logic [3:0]  be;
        logic [31:0] wdat;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        err_o;
        logic [3:0]  be_o;
        logic [31:0] wdat_o;
        int          ndone;
        logic        wr_seen;
        logic [31:0] exp_rd;

        nerr = 0; nchk = 0;
        Reset_signal = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; sign_ext = 1'b0;
        Addr = '0; WriteData = '0; pre_we = 1'b0; pre_idx = '0; pre_val = '0; ref_rd = '0;

        //            w     sz     sx    a      wd            pre   mword         err   be       wdat          rd
        tbl[0]  = '{1'b0, 2'b00, 1'b0, 8'h10, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 4'h0,    32'h0,        32'hDEADBEEF};
        tbl[1]  = '{1'b0, 2'b10, 1'b1, 8'h13, 32'h0,        1'b1, 32'h80FF1234, 1'b0, 4'h0,    32'h0,        32'hFFFFFF80};
        tbl[2]  = '{1'b0, 2'b10, 1'b0, 8'h13, 32'h0,        1'b0, 32'h0,        1'b0, 4'h0,    32'h0,        32'h00000080};
        tbl[3]  = '{1'b1, 2'b01, 1'b0, 8'h22, 32'h0000ABCD, 1'b1, 32'h11111111, 1'b0, 4'b1100, 32'hABCDABCD, 32'h00000080};
        tbl[4]  = '{1'b0, 2'b01, 1'b1, 8'h22, 32'h0,        1'b0, 32'h0,        1'b0, 4'h0,    32'h0,        32'hFFFFABCD};
        tbl[5]  = '{1'b0, 2'b00, 1'b0, 8'h06, 32'h0,        1'b0, 32'h0,        1'b1, 4'h0,    32'h0,        32'hFFFFABCD};
        tbl[6]  = '{1'b1, 2'b10, 1'b0, 8'h31, 32'h1234565A, 1'b1, 32'h0,        1'b0, 4'b0010, 32'h5A5A5A5A, 32'hFFFFABCD};
        tbl[7]  = '{1'b0, 2'b00, 1'b0, 8'h30, 32'h0,        1'b0, 32'h0,        1'b0, 4'h0,    32'h0,        32'h00005A00};
        tbl[8]  = '{1'b0, 2'b01, 1'b0, 8'h23, 32'h0,        1'b0, 32'h0,        1'b1, 4'h0,    32'h0,        32'h00005A00};
        tbl[9]  = '{1'b0, 2'b11, 1'b0, 8'h10, 32'h0,        1'b0, 32'h0,        1'b0, 4'h0,    32'h0,        32'h80FF1234};
        tbl[10] = '{1'b0, 2'b11, 1'b0, 8'h12, 32'h0,        1'b0, 32'h0,        1'b1, 4'h0,    32'h0,        32'h80FF1234};
        tbl[11] = '{1'b0, 2'b01, 1'b0, 8'h12, 32'h0,        1'b0, 32'h0,        1'b0, 4'h0,    32'h0,        32'h000080FF};
        tbl[12] = '{1'b0, 2'b10, 1'b1, 8'h31, 32'h0,        1'b0, 32'h0,        1'b0, 4'h0,    32'h0,        32'h0000005A};
        tbl[13] = '{1'b1, 2'b00, 1'b0, 8'h40, 32'hCAFEF00D, 1'b1, 32'h0,        1'b0, 4'b1111, 32'hCAFEF00D, 32'h0000005A};
        tbl[14] = '{1'b0, 2'b10, 1'b1, 8'h42, 32'h0,        1'b0, 32'h0,        1'b0, 4'h0,    32'h0,        32'hFFFFFFFE};

        @(negedge Clk);
        for (int i = 0; i < 64; i++) preload(6'(i), $urandom);

        chk("rst_readdata", ReadData, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr_err", addr_err, 1'b0);
        chk("rst_mem_wr", Mem_wr, 1'b0);
        chk("rst_byte_en", Mem_byte_en, 4'b0000);
        chk("rst_mem_addr", Mem_addr, 32'h0);
        chk("rst_mem_wdata", Mem_wdata, 32'h0);
        Reset_signal = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].pre) preload(tbl[i].a[7:2], tbl[i].mword);
            txn(tbl[i].w, tbl[i].sz, tbl[i].sx, tbl[i].a, tbl[i].wd, err_o, be_o, wdat_o);
            chk($sformatf("vec%0d_err", i), err_o, tbl[i].err);
            if (tbl[i].w && !tbl[i].err) begin
                chk($sformatf("vec%0d_be", i), be_o, tbl[i].be);
                chk($sformatf("vec%0d_wdata", i), wdat_o, tbl[i].wdat);
            end
            chk($sformatf("vec%0d_readdata", i), ReadData, tbl[i].rd);
        end

        // Request held high through a read (as a store to 0x40) must be ignored until idle.
        exp_rd = ref_mem[8];
        req = 1'b1; wr = 1'b0; size = 2'b00; sign_ext = 1'b0; Addr = 32'h20;
        @(negedge Clk);
        wr = 1'b1; Addr = 32'h40; WriteData = 32'hFFFFFFFF;
        ndone = 0; wr_seen = 1'b0;
        for (int k = 0; k <= RL; k++) begin
            chk("ign_addr", Mem_addr, 32'h20);
            if (done) ndone++;
            if (Mem_wr) wr_seen = 1'b1;
            @(negedge Clk);
        end
        chk("ign_not_accepted_in_done", busy, 1'b0);
        req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (done) ndone++;
            if (Mem_wr) wr_seen = 1'b1;
            @(negedge Clk);
        end
        chk("ign_done_count", ndone, 1);
        chk("ign_no_write", wr_seen, 1'b0);
        chk("ign_readdata", ReadData, exp_rd);
        ref_rd = exp_rd;

        // Asynchronous reset between edges while a read is in flight (cnt=1).
        req = 1'b1; wr = 1'b0; size = 2'b00; Addr = 32'h10;
        @(negedge Clk);
        req = 1'b0;
        @(posedge Clk);
        #2 Reset_signal = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_addr_err", addr_err, 1'b0);
        chk("arst_readdata", ReadData, 32'h0);
        chk("arst_mem_addr", Mem_addr, 32'h0);
        chk("arst_mem_wr", Mem_wr, 1'b0);
        chk("arst_byte_en", Mem_byte_en, 4'b0000);
        chk("arst_mem_wdata", Mem_wdata, 32'h0);
        ref_rd = '0;
        @(negedge Clk);
        @(negedge Clk);
        Reset_signal = 1'b0;
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            if (done || busy) ndone++;
            @(negedge Clk);
        end
        chk("arst_abandoned", ndone, 0);
        txn(1'b0, 2'b00, 1'b0, 8'h10, 32'h0, err_o, be_o, wdat_o);
        chk("arst_recover_err", err_o, 1'b0);

        for (int i = 0; i < 40; i++)
            txn(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), $urandom,
                err_o, be_o, wdat_o);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side stage directly downstream of the multicycle control FSM. It replaces the fixed FETCH_MEM_DELAY wait states with a request/done handshake.
- Accepts one load, store or fetch request at a time and drives the synchronous 32-bit memory with byte enables.
- Waits a parameterised read latency, aligns and extends load data into a holding register, and flags misaligned accesses.
- ReadData feeds the IR/MDR load path; done tells the control FSM it may advance.

Parameters:
- READ_LATENCY, 2, number of clock edges from address presentation to valid Mem_rdata; legal range 1..7.
- ADDR_WIDTH, 32, byte-address width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_signal  in  1  asynchronous, active-high reset.
- req  in  1  request strobe; sampled only when busy=0.
- wr  in  1  1 = store, 0 = load/fetch.
- size  in  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as word).
- sign_ext  in  1  loads only: 1 sign-extends sub-word data, 0 zero-extends.
- Addr  in  ADDR_WIDTH  byte address.
- WriteData  in  32  store data, right-aligned.
- ReadData  out  32  aligned and extended load result (registered).
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when an access completes successfully.
- addr_err  out  1  one-cycle pulse for a misaligned request.
- Mem_addr  out  ADDR_WIDTH  word-aligned address {addr_q[ADDR_WIDTH-1:2],2'b00}.
- Mem_wdata  out  32  lane-replicated store data.
- Mem_wr  out  1  memory write enable.
- Mem_byte_en  out  4  byte lane enables; 0000 whenever Mem_wr=0.
- Mem_rdata  in  32  memory read data.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs and capture registers = 0. Any in-flight access is abandoned with no done and no addr_err.
- States: IDLE, READ, WRITE, DONE, ERR.
- IDLE, req=1 at edge E0: capture Addr, wr, size, sign_ext, WriteData into *_q.
  - Misaligned (half with Addr[0]=1, word with Addr[1:0]!=0): go to ERR.
  - Otherwise wr=1 goes to WRITE, wr=0 goes to READ with cnt=0.
- req while busy=1 is ignored; no queuing.
- ERR: addr_err=1 for exactly one cycle (E0..E0+1). No memory access (Mem_wr=0). Returns to IDLE; ReadData unchanged.
- WRITE (cycle E0..E0+1): Mem_wr=1.
  - Byte lane n = Addr[1:0], little-endian.
  - Byte: Mem_byte_en = 1<<n, Mem_wdata = {4{WD[7:0]}}.
  - Half: Mem_byte_en = 0011 or 1100 (by Addr[1]), Mem_wdata = {2{WD[15:0]}}.
  - Word: Mem_byte_en = 1111, Mem_wdata = WD.
  - Next state DONE.
- READ: Mem_addr is stable from E0 onward; cnt increments each edge.
  - At edge E0+READ_LATENCY, sample Mem_rdata: select lane(s) by addr_q[1:0], right-align, extend per size_q/sign_ext_q, and load ReadData.
  - Next state DONE.
- DONE: done=1 for one cycle, then IDLE. A new req is accepted at the first edge with state=IDLE (busy=0), i.e. the edge ending the DONE cycle is not an accept edge.
- Latency, accept edge to done high: read READ_LATENCY cycles; write 1 cycle. Accept edge to addr_err high: 0 cycles.
- ReadData holds its last load value across writes, errors and idle. It is cleared only by reset.
- busy is high from E0 until the cycle after done/addr_err deasserts state to IDLE.
- Size 11 behaves exactly as word (alignment check included).

Test Plan:
- Word read, READ_LATENCY=2, Addr=0x0000_0010, memory word 0xDEAD_BEEF -> Mem_addr=0x10, done high at E0+2, ReadData=0xDEADBEEF, Mem_wr never high.
- Byte read, sign_ext=1, Addr=0x13, mem 0x80FF_1234 -> ReadData=0xFFFF_FF80. Repeat with sign_ext=0 -> 0x0000_0080.
- Half write, Addr=0x22, WriteData=0x0000_ABCD -> single cycle Mem_wr=1, Mem_byte_en=1100, Mem_wdata=0xABCD_ABCD, Mem_addr=0x20, done next cycle.
- Misaligned word read, Addr=0x06 -> addr_err one cycle, done never, Mem_wr=0, ReadData unchanged, busy low after one cycle.
- Second req pulsed during READ with Addr=0x40 -> ignored; Mem_addr stays at first address; exactly one done.
- Reset_signal asserted mid-READ (cnt=1), asynchronously between edges -> outputs 0 immediately, state IDLE, no done. A new word read after release completes normally.
